// File: rtl/uart_mem_responder.sv
// uart_mem_responder: far-end byte responder for the bitty LSU link.
// Decodes store (01,addr,hi,lo) and load (02,addr) frames arriving from the
// UART receiver. Serves them from a 16-bit word memory and returns ACK or the
// two data bytes through the UART transmitter handshake.
module uart_mem_responder #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned TIMEOUT  = 100000,
    parameter logic [7:0]  ACK_BYTE = 8'hAA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_done,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_err
);
    localparam int unsigned      CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       CMD_STORE = 8'h01;
    localparam logic [7:0]       CMD_LOAD  = 8'h02;
    localparam int unsigned      DEPTH     = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_DHI,
        S_DLO,
        S_WRITE,
        S_READ,
        S_TX_HI,
        S_TX_LO,
        S_TX_ACK
    } state_t;

    state_t            state, state_next;
    logic              is_store, is_store_next;
    logic [CNT_W-1:0]  idle_cnt, idle_cnt_next;
    logic              tx_en_next;
    logic [7:0]        tx_data_next;
    logic              frame_err_next;

    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       rd_q;
    logic [15:0]       mem [DEPTH];

    logic              collecting;
    logic              timed_out;
    logic              tx_ready;

    // Only the frame-collection states run the inter-byte timer.
    assign collecting = (state == S_ADDR) || (state == S_DHI) || (state == S_DLO);
    assign timed_out  = collecting && !rx_done && (idle_cnt == CNT_LAST);
    // A transmitter cannot finish a byte in the cycle it was started, so a
    // tx_done coinciding with tx_en is ignored; this also keeps tx_en from
    // ever firing on two consecutive cycles.
    assign tx_ready   = tx_done && !tx_en;
    assign busy       = (state != S_IDLE);

    // Next-state, response byte and error decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_next     = state;
        is_store_next  = is_store;
        tx_en_next     = 1'b0;
        tx_data_next   = tx_data;
        frame_err_next = 1'b0;
        idle_cnt_next  = (collecting && !rx_done) ? idle_cnt + 1'b1 : '0;

        // A byte arriving while a frame is being executed or answered is lost.
        if (rx_done && !collecting && (state != S_IDLE)) begin
            frame_err_next = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (rx_done) begin
                    if (rx_data == CMD_STORE) begin
                        is_store_next = 1'b1;
                        state_next    = S_ADDR;
                    end else if (rx_data == CMD_LOAD) begin
                        is_store_next = 1'b0;
                        state_next    = S_ADDR;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (rx_done) state_next = is_store ? S_DHI : S_READ;
            end
            S_DHI: begin
                if (rx_done) state_next = S_DLO;
            end
            S_DLO: begin
                if (rx_done) state_next = S_WRITE;
            end
            S_WRITE: begin
                tx_data_next = ACK_BYTE;
                tx_en_next   = 1'b1;
                state_next   = S_TX_ACK;
            end
            S_READ: begin
                tx_data_next = rd_q[15:8];
                tx_en_next   = 1'b1;
                state_next   = S_TX_HI;
            end
            S_TX_HI: begin
                if (tx_ready) begin
                    tx_data_next = rd_q[7:0];
                    tx_en_next   = 1'b1;
                    state_next   = S_TX_LO;
                end
            end
            S_TX_LO, S_TX_ACK: begin
                if (tx_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Abandon a stalled frame; nothing has been written yet.
        if (timed_out) begin
            frame_err_next = 1'b1;
            state_next     = S_IDLE;
        end
    end

    // Control state, inter-byte timer and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before the clock edge.
        if (reset) begin
            state     <= S_IDLE;
            is_store  <= 1'b0;
            idle_cnt  <= '0;
            tx_en     <= 1'b0;
            tx_data   <= 8'h00;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            is_store  <= is_store_next;
            idle_cnt  <= idle_cnt_next;
            tx_en     <= tx_en_next;
            tx_data   <= tx_data_next;
            frame_err <= frame_err_next;
        end
    end

    // Capture frame fields as their bytes arrive.
    always_ff @(posedge clk) begin
        if (rx_done) begin
            case (state)
                S_ADDR:  addr        <= rx_data[ADDR_W-1:0];
                S_DHI:   wdata[15:8] <= rx_data;
                S_DLO:   wdata[7:0]  <= rx_data;
                default: ;
            endcase
        end
    end

    // Word memory: written in WRITE, read as the load address byte arrives so
    // the high byte can go out in the following READ cycle.
    always_ff @(posedge clk) begin
        // NOTE: the memory array is deliberately not reset so it maps onto a
        // plain RAM; words hold whatever was last stored.
        if (state == S_WRITE) begin
            mem[addr] <= wdata;
        end
        if ((state == S_ADDR) && rx_done && !is_store) begin
            rd_q <= mem[rx_data[ADDR_W-1:0]];
        end
    end

endmodule

// File: tb/tb_uart_mem_responder.sv
// tb_uart_mem_responder: directed scenarios plus a randomized load/store mix,
// checked against an array model of the memory and the frame rules.
module tb_uart_mem_responder;
    localparam int         TIMEOUT = 40;
    localparam logic [7:0] ACK     = 8'hAA;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_err;

    uart_mem_responder #(
        .ADDR_W  (8),
        .TIMEOUT (TIMEOUT),
        .ACK_BYTE(ACK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_done  (tx_done),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .busy     (busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } tx_ev_t;

    tx_ev_t      tx_q[$];
    tx_ev_t      ev;
    int          cyc          = 0;
    int          last_rx_cyc  = 0;
    int          last_txd_cyc = 0;
    int          ferr_cnt     = 0;
    int          ferr_cyc     = 0;
    int          consec       = 0;
    logic        prev_tx_en   = 1'b0;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          exp_ferr = 0;

    logic [15:0] model_mem [256];
    bit          valid     [256];
    logic [7:0]  written[$];

    // Cycle counter and event log of everything the DUT emits.
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (tx_en === 1'b1) begin
            ev.cyc  = cyc;
            ev.data = tx_data;
            tx_q.push_back(ev);
        end
        if (tx_en === 1'b1 && prev_tx_en === 1'b1) consec++;
        prev_tx_en = tx_en;
        if (frame_err === 1'b1) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
        if (rx_done) last_rx_cyc = cyc;
        if (tx_done) last_txd_cyc = cyc;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        for (int i = 0; i < 30 && tx_q.size() < n; i++) tick();
        check(tag, tx_q.size(), n);
    endtask

    task automatic do_store(input logic [7:0] a, input logic [15:0] d, input int gap);
        int n0;
        n0 = tx_q.size();
        send_byte(8'h01);
        idle(gap);
        send_byte(a);
        idle(gap);
        send_byte(d[15:8]);
        idle(gap);
        send_byte(d[7:0]);
        wait_tx(n0 + 1, "store ack count");
        if (tx_q.size() > n0) begin
            check("store ack data", 32'(tx_q[n0].data), 32'(ACK));
            check("store ack latency", tx_q[n0].cyc - last_rx_cyc, 2);
        end
        model_mem[a] = d;
        if (!valid[a]) written.push_back(a);
        valid[a] = 1'b1;
        idle($urandom_range(0, 3));
        pulse_tx_done();
        check("store done busy", 32'(busy), 0);
        idle(2);
        check("store tx total", tx_q.size(), n0 + 1);
        check("store frame_err", ferr_cnt, exp_ferr);
    endtask

    task automatic do_load(input logic [7:0] a, input int gap, input bit inject);
        int          n0;
        logic [15:0] exp_w;
        n0    = tx_q.size();
        exp_w = model_mem[a];
        send_byte(8'h02);
        idle(gap);
        send_byte(a);
        wait_tx(n0 + 1, "load hi count");
        if (tx_q.size() > n0) begin
            check("load hi data", 32'(tx_q[n0].data), 32'(exp_w[15:8]));
            check("load hi latency", tx_q[n0].cyc - last_rx_cyc, 2);
        end
        if (inject) begin
            send_byte(8'h55);
            tick();
            exp_ferr++;
            check("dropped byte err", ferr_cnt, exp_ferr);
            check("dropped byte busy", 32'(busy), 1);
        end
        idle($urandom_range(0, 3));
        pulse_tx_done();
        wait_tx(n0 + 2, "load lo count");
        if (tx_q.size() > n0 + 1) begin
            check("load lo data", 32'(tx_q[n0+1].data), 32'(exp_w[7:0]));
            check("load lo latency", tx_q[n0+1].cyc - last_txd_cyc, 1);
        end
        idle($urandom_range(0, 3));
        pulse_tx_done();
        check("load done busy", 32'(busy), 0);
        idle(2);
        check("load tx total", tx_q.size(), n0 + 2);
        check("load frame_err", ferr_cnt, exp_ferr);
    endtask

    task automatic bad_byte(input logic [7:0] b);
        int n0;
        n0 = tx_q.size();
        send_byte(b);
        tick();
        exp_ferr++;
        check("bad cmd err", ferr_cnt, exp_ferr);
        check("bad cmd busy", 32'(busy), 0);
        check("bad cmd no tx", tx_q.size(), n0);
    endtask

    // Send the first n bytes of a frame, then go silent until the abort.
    task automatic abort_frame(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input int n);
        int n0;
        n0 = tx_q.size();
        send_byte(b0);
        if (n > 1) send_byte(b1);
        if (n > 2) send_byte(b2);
        for (int i = 0; i < TIMEOUT + 10 && ferr_cnt == exp_ferr; i++) tick();
        exp_ferr++;
        check("timeout err", ferr_cnt, exp_ferr);
        check("timeout latency", ferr_cyc - last_rx_cyc, TIMEOUT + 1);
        check("timeout busy", 32'(busy), 0);
        check("timeout no tx", tx_q.size(), n0);
    endtask

    task automatic reset_in_tx(input logic [7:0] a);
        int n0;
        n0 = tx_q.size();
        send_byte(8'h02);
        send_byte(a);
        wait_tx(n0 + 1, "reset load hi count");
        if (tx_q.size() > n0) begin
            check("reset load hi data", 32'(tx_q[n0].data), 32'(model_mem[a][15:8]));
        end
        reset = 1'b1;
        tick();
        check("reset tx_en", 32'(tx_en), 0);
        check("reset busy", 32'(busy), 0);
        reset = 1'b0;
        pulse_tx_done();
        idle(4);
        check("reset no more tx", tx_q.size(), n0 + 1);
        check("reset still idle", 32'(busy), 0);
    endtask

    task automatic stray_tx_done();
        int n0;
        n0 = tx_q.size();
        pulse_tx_done();
        idle(2);
        check("stray tx_done no tx", tx_q.size(), n0);
        check("stray tx_done busy", 32'(busy), 0);
    endtask

    function automatic logic [7:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 8'h00;
        if (r == 1) return 8'hFF;
        return 8'($urandom_range(0, 15) * 16 + $urandom_range(0, 3));
    endfunction

    initial begin
        int         sel;
        logic [7:0] a;

        reset   = 1'b1;
        rx_done = 1'b0;
        tx_done = 1'b0;
        rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset tx_en", 32'(tx_en), 0);
        check("reset tx_data", 32'(tx_data), 0);
        check("reset busy", 32'(busy), 0);
        check("reset frame_err", 32'(frame_err), 0);
        reset = 1'b0;
        tick();

        // Basic store, then load back.
        do_store(8'h10, 16'hBEEF, 0);
        do_load(8'h10, 0, 1'b0);

        // Unknown commands, including the byte values around 01/02.
        bad_byte(8'h7F);
        bad_byte(8'h00);
        bad_byte(8'h03);
        bad_byte(8'hFF);
        do_load(8'h10, 0, 1'b0);

        // Timeouts in each collection state leave memory untouched.
        do_store(8'h20, 16'h1234, 1);
        abort_frame(8'h01, 8'h20, 8'h99, 2);
        do_load(8'h20, 0, 1'b0);
        abort_frame(8'h01, 8'h20, 8'h99, 3);
        do_load(8'h20, 0, 1'b0);
        abort_frame(8'h02, 8'h20, 8'h00, 1);
        abort_frame(8'h01, 8'h00, 8'h00, 1);

        // Longest gap that must not time out.
        do_store(8'h30, 16'($urandom), TIMEOUT - 1);
        do_load(8'h30, TIMEOUT - 1, 1'b0);

        // Byte arriving during the response is dropped.
        do_load(8'h10, 0, 1'b1);

        // Reset while waiting on the transmitter, then normal traffic.
        reset_in_tx(8'h10);
        stray_tx_done();
        do_store(8'hFF, 16'($urandom), 0);
        do_store(8'h00, 16'($urandom), 0);
        do_load(8'hFF, 0, 1'b0);
        do_load(8'h00, 0, 1'b0);

        // Randomized mix.
        for (int k = 0; k < 50; k++) begin
            sel = $urandom_range(0, 11);
            if (sel < 3 || written.size() == 0) begin
                do_store(pick_addr(), 16'($urandom), $urandom_range(0, 3));
            end else if (sel == 3) begin
                a = pick_addr();
                do_store(a, 16'($urandom), $urandom_range(0, 2));
                do_load(a, $urandom_range(0, 2), 1'b0);
            end else if (sel < 9) begin
                a = written[$urandom_range(0, written.size() - 1)];
                do_load(a, $urandom_range(0, 3), sel == 8);
            end else if (sel == 9) begin
                bad_byte(8'($urandom_range(3, 255)));
            end else if (sel == 10) begin
                stray_tx_done();
            end else begin
                abort_frame(8'h01, pick_addr(), 8'($urandom), $urandom_range(1, 3));
            end
            idle($urandom_range(0, 2));
        end

        check("frame_err total", ferr_cnt, exp_ferr);
        check("no back-to-back tx_en", consec, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
